// File: rtl/frame_buf_pkg.sv
// Shared frame geometry and scheduler types for frame_buf_sched.
package frame_buf_pkg;

  localparam int FRAME_W     = 640;
  localparam int FRAME_H     = 480;
  localparam int FRAME_WORDS = FRAME_W * FRAME_H;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY
  } sched_state_t;

  typedef logic [22:0] addr_t;

endpackage

// File: rtl/frame_buf_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, with wrap.
module rr_arbiter
  import frame_buf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick
);

  logic          found;
  logic [PW-1:0] idx;
  int            sum;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buf_sched.sv
// Ping-pong frame-buffer scheduler for one SDRAM command port.
// Define PRIORITY_WR_EN to give the writer (req[0]) strict priority.
module frame_buf_sched
  import frame_buf_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 23,
  parameter int FRAME_WORDS = frame_buf_pkg::FRAME_WORDS,
  parameter int BURST       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               freeze,
  output logic [NUM_REQ-1:0] gnt,
  output logic               mem_cmd_valid,
  output logic               mem_cmd_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_burst_done,
  output logic [NUM_REQ-1:0] frame_done,
  output logic               wr_bank
);

  localparam int PW = $clog2(NUM_REQ);

  sched_state_t        state;
  sched_state_t        nstate;
  logic [PW-1:0]       w;
  logic [PW-1:0]       p;
  logic [PW-1:0]       win;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  pick;
  logic                adv;
  logic [ADDR_W-1:0]   off [NUM_REQ];
  logic [ADDR_W-1:0]   nxt_off;
  logic                wrap;
  logic                bank;

`ifdef PRIORITY_WR_EN
  assign arb_req = {req[NUM_REQ-1:1], 1'b0};
  assign adv     = ~req[0];
`else
  assign arb_req = req;
  assign adv     = 1'b1;
`endif

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_arb (
    .req (arb_req),
    .ptr (p),
    .pick(pick)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) win = PW'(i);
`ifdef PRIORITY_WR_EN
    if (req[0]) win = '0;
`endif
  end

  assign nxt_off = off[w] + ADDR_W'(BURST);
  assign wrap    = (nxt_off == ADDR_W'(FRAME_WORDS));
  assign bank    = (w == '0) ? wr_bank : ~wr_bank;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (|req)          nstate = ISSUE;
      ISSUE:   if (mem_ready)      nstate = BUSY;
      BUSY:    if (mem_burst_done) nstate = IDLE;
      default:                     nstate = IDLE;
    endcase
  end

  // Winner, pointer, offsets and bank only move at IDLE pick / BUSY completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w          <= '0;
      p          <= '0;
      wr_bank    <= 1'b0;
      frame_done <= '0;
      for (int i = 0; i < NUM_REQ; i++) off[i] <= '0;
    end else begin
      frame_done <= '0;
      if (state == IDLE && |req) begin
        w <= win;
        if (adv) p <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == BUSY && mem_burst_done) begin
        off[w] <= wrap ? '0 : nxt_off;
        if (wrap) begin
          frame_done[w] <= 1'b1;
          if (w == '0 && !freeze) wr_bank <= ~wr_bank;
        end
      end
    end
  end

  always_comb begin
    gnt           = '0;
    mem_cmd_valid = (state == ISSUE);
    mem_cmd_wr    = 1'b0;
    mem_addr      = '0;
    if (state != IDLE) begin
      gnt[w]     = 1'b1;
      mem_cmd_wr = (w == '0);
      mem_addr   = (bank ? ADDR_W'(FRAME_WORDS) : '0) + off[w];
    end
  end

endmodule
